// File: rtl/instr_mem_loader_pkg.sv
// Shared types and defaults for the debug-loadable instruction memory.
// Latency: n/a; backpressure: n/a.
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int          DEF_DATA_W    = 32;
    localparam logic [63:0] DEF_NOP_WORD  = 64'h0;
    localparam logic [63:0] DEF_HALT_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Debug-load stream, fetch port and status of the instruction memory.
// Latency: n/a; backpressure: none, one byte accepted per cycle.
interface instr_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 64
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              load_start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              run_start;
    logic [PC_W-1:0]   pc_addr;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              addr_err;
    logic              loading;
    logic              program_loaded;
    logic [CW-1:0]     word_count;

    modport master (
        output load_start, byte_valid, byte_data, run_start, pc_addr, stall, flush,
        input  instr, instr_valid, addr_err, loading, program_loaded, word_count
    );

    modport slave (
        input  load_start, byte_valid, byte_data, run_start, pc_addr, stall, flush,
        output instr, instr_valid, addr_err, loading, program_loaded, word_count
    );

endinterface

// File: rtl/instr_word_assembler.sv
// Packs a big-endian byte stream into DATA_W words.
// Latency: word_vld_o is combinational with the last byte; backpressure: none.
module instr_word_assembler import instr_mem_loader_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_dat_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_vld_o
);
    localparam int BYTES = bytes_per_word(DATA_W);
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    if (BYTES == 1) begin : g_single
        assign word_o     = byte_dat_i;
        assign word_vld_o = byte_vld_i;
    end else begin : g_multi
        logic [DATA_W-9:0] shift_q, shift_d;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic              last;

        assign last       = (cnt_q == CW'(BYTES - 1));
        assign word_o     = {shift_q, byte_dat_i};
        assign word_vld_o = byte_vld_i & last;

        always_comb begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
            if (clear_i) begin
                shift_d = '0;
                cnt_d   = '0;
            end else if (byte_vld_i) begin
                shift_d = word_o[DATA_W-9:0];
                cnt_d   = last ? '0 : cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else begin
                shift_q <= shift_d;
                cnt_q   <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loaded from a debug byte stream, fetched by the IF stage.
// Latency: 1 cycle pc_addr -> instr; backpressure: none, stall holds the output.
module instr_mem_loader import instr_mem_loader_pkg::*; #(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = 64,
    parameter int                PC_W      = 32,
    parameter int                BYTE_ADDR = 1,
    parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(DEF_NOP_WORD),
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEF_HALT_WORD)
) (
    input  logic               clk,
    input  logic               rst,
    instr_mem_loader_if.slave  bus
);
    localparam int BYTES = bytes_per_word(DATA_W);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;

    state_e            state_q, state_d;
    logic [CW-1:0]     wc_q, wc_d;
    logic              loaded_q, loaded_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              ivld_q, ivld_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              asm_byte_vld;
    logic              word_vld;
    logic [DATA_W-1:0] word;
    logic              mem_we;
    logic [AW-1:0]     wr_ptr;
    logic [PC_W-1:0]   fetch_idx;
    logic              in_range;

    // Bytes arriving alongside load_start are dropped: the restart wins.
    assign asm_byte_vld = (state_q == ST_LOAD) & bus.byte_valid & ~bus.load_start;

    instr_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (bus.load_start),
        .byte_vld_i (asm_byte_vld),
        .byte_dat_i (bus.byte_data),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    // Words written so far double as the write pointer.
    assign wr_ptr    = wc_q[AW-1:0];
    assign mem_we    = word_vld & ~rst;
    assign fetch_idx = (BYTE_ADDR != 0) ? (bus.pc_addr >> SHIFT) : bus.pc_addr;
    assign in_range  = (fetch_idx < PC_W'(wc_q));

    always_comb begin
        state_d  = state_q;
        wc_d     = wc_q;
        loaded_d = loaded_q;
        instr_d  = NOP_WORD;
        ivld_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_d  = ST_LOAD;
                    wc_d     = '0;
                    loaded_d = 1'b0;
                end else if (bus.run_start && loaded_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (bus.load_start) begin
                    wc_d = '0;
                end else if (word_vld) begin
                    wc_d = wc_q + CW'(1);
                    if (word == HALT_WORD || wr_ptr == AW'(DEPTH - 1)) begin
                        state_d  = ST_IDLE;
                        loaded_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.load_start) begin
                    state_d  = ST_LOAD;
                    wc_d     = '0;
                    loaded_d = 1'b0;
                end else if (bus.flush) begin
                    instr_d = NOP_WORD;
                end else if (bus.stall) begin
                    instr_d = instr_q;
                    ivld_d  = ivld_q;
                end else if (in_range) begin
                    instr_d = mem[fetch_idx[AW-1:0]];
                    ivld_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wc_q     <= '0;
            loaded_q <= 1'b0;
            instr_q  <= NOP_WORD;
            ivld_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wc_q     <= wc_d;
            loaded_q <= loaded_d;
            instr_q  <= instr_d;
            ivld_q   <= ivld_d;
            err_q    <= err_d;
        end
    end

    // Array deliberately unreset so a program survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= word;
        end
    end

    assign bus.instr          = instr_q;
    assign bus.instr_valid    = ivld_q;
    assign bus.addr_err       = err_q;
    assign bus.loading        = (state_q == ST_LOAD);
    assign bus.program_loaded = loaded_q;
    assign bus.word_count     = wc_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: 64-deep main instance and a 4-deep instance for the full-memory case.
module tb_instr_mem_loader;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    instr_mem_loader_if #(.DATA_W(32), .PC_W(32), .DEPTH(64)) bus0 ();
    instr_mem_loader_if #(.DATA_W(32), .PC_W(32), .DEPTH(4))  bus1 ();

    instr_mem_loader #(.DATA_W(32), .DEPTH(64), .PC_W(32), .BYTE_ADDR(1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    instr_mem_loader #(.DATA_W(32), .DEPTH(4), .PC_W(32), .BYTE_ADDR(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            if (!sel) begin
                bus0.byte_valid = 1'b1;
                bus0.byte_data  = w[31-8*i -: 8];
            end else begin
                bus1.byte_valid = 1'b1;
                bus1.byte_data  = w[31-8*i -: 8];
            end
            tick();
        end
        bus0.byte_valid = 1'b0;
        bus1.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus0.instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want %h", bus0.instr, 32'h0); end
        total++; if (bus0.instr_valid !== 1'b0 || bus0.addr_err !== 1'b0) begin bad++; $display("FAIL reset_vld_err: got %b%b want 00", bus0.instr_valid, bus0.addr_err); end
        total++; if (bus0.loading !== 1'b0 || bus0.program_loaded !== 1'b0) begin bad++; $display("FAIL reset_flags: got %b%b want 00", bus0.loading, bus0.program_loaded); end
        total++; if (bus0.word_count !== 7'd0) begin bad++; $display("FAIL reset_wc: got %0d want 0", bus0.word_count); end
        bus0.run_start = 1'b1;
        tick();
        bus0.run_start = 1'b0;
        tick();
        total++; if (bus0.instr_valid !== 1'b0 || bus0.instr !== 32'h0 || bus0.loading !== 1'b0) begin bad++; $display("FAIL run_unloaded: got vld=%b instr=%h load=%b want 0 0 0", bus0.instr_valid, bus0.instr, bus0.loading); end
    endtask

    task automatic test_load();
        bus0.load_start = 1'b1;
        tick();
        bus0.load_start = 1'b0;
        total++; if (bus0.loading !== 1'b1 || bus0.word_count !== 7'd0) begin bad++; $display("FAIL load_entry: got load=%b wc=%0d want 1 0", bus0.loading, bus0.word_count); end
        send_word(1'b0, 32'h2022_1820);
        total++; if (bus0.word_count !== 7'd1 || bus0.loading !== 1'b1) begin bad++; $display("FAIL load_word1: got wc=%0d load=%b want 1 1", bus0.word_count, bus0.loading); end
        send_word(1'b0, 32'hFFFF_FFFF);
        total++; if (bus0.word_count !== 7'd2) begin bad++; $display("FAIL load_halt_wc: got %0d want 2", bus0.word_count); end
        total++; if (bus0.program_loaded !== 1'b1 || bus0.loading !== 1'b0) begin bad++; $display("FAIL load_halt_flags: got loaded=%b load=%b want 1 0", bus0.program_loaded, bus0.loading); end
    endtask

    task automatic test_fetch();
        bus0.pc_addr   = 32'd0;
        bus0.run_start = 1'b1;
        tick();
        bus0.run_start = 1'b0;
        total++; if (bus0.instr_valid !== 1'b0) begin bad++; $display("FAIL fetch_transition: got vld=%b want 0", bus0.instr_valid); end
        tick();
        total++; if (bus0.instr !== 32'h2022_1820 || bus0.instr_valid !== 1'b1) begin bad++; $display("FAIL fetch_w0: got %h/%b want 20221820/1", bus0.instr, bus0.instr_valid); end
        bus0.pc_addr = 32'd5;
        tick();
        total++; if (bus0.instr !== 32'hFFFF_FFFF || bus0.instr_valid !== 1'b1) begin bad++; $display("FAIL fetch_w1_unaligned: got %h/%b want ffffffff/1", bus0.instr, bus0.instr_valid); end
    endtask

    task automatic test_addr_err();
        bus0.pc_addr = 32'd8;
        tick();
        total++; if (bus0.instr !== 32'h0 || bus0.instr_valid !== 1'b0 || bus0.addr_err !== 1'b1) begin bad++; $display("FAIL oob_fetch: got %h/%b/%b want 0/0/1", bus0.instr, bus0.instr_valid, bus0.addr_err); end
        bus0.pc_addr = 32'd0;
        tick();
        total++; if (bus0.addr_err !== 1'b0 || bus0.instr !== 32'h2022_1820) begin bad++; $display("FAIL oob_pulse_end: got err=%b instr=%h want 0 20221820", bus0.addr_err, bus0.instr); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] pcs [3];
        pcs[0] = 32'd4; pcs[1] = 32'd8; pcs[2] = 32'd4;
        bus0.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus0.pc_addr = pcs[i];
            tick();
            total++; if (bus0.instr !== 32'h2022_1820 || bus0.instr_valid !== 1'b1 || bus0.addr_err !== 1'b0) begin bad++; $display("FAIL stall_hold_%0d: got %h/%b/%b want 20221820/1/0", i, bus0.instr, bus0.instr_valid, bus0.addr_err); end
        end
        bus0.stall = 1'b0;
        tick();
        total++; if (bus0.instr !== 32'hFFFF_FFFF || bus0.instr_valid !== 1'b1) begin bad++; $display("FAIL stall_release: got %h/%b want ffffffff/1", bus0.instr, bus0.instr_valid); end
        bus0.stall = 1'b1;
        bus0.flush = 1'b1;
        tick();
        total++; if (bus0.instr !== 32'h0 || bus0.instr_valid !== 1'b0) begin bad++; $display("FAIL flush_over_stall: got %h/%b want 0/0", bus0.instr, bus0.instr_valid); end
        bus0.stall = 1'b0;
        bus0.flush = 1'b0;
        tick();
        total++; if (bus0.instr !== 32'hFFFF_FFFF || bus0.instr_valid !== 1'b1) begin bad++; $display("FAIL after_flush: got %h/%b want ffffffff/1", bus0.instr, bus0.instr_valid); end
        bus0.load_start = 1'b1;
        tick();
        bus0.load_start = 1'b0;
        total++; if (bus0.instr !== 32'h0 || bus0.instr_valid !== 1'b0 || bus0.loading !== 1'b1) begin bad++; $display("FAIL run_abort: got %h/%b load=%b want 0/0 1", bus0.instr, bus0.instr_valid, bus0.loading); end
        total++; if (bus0.program_loaded !== 1'b0 || bus0.word_count !== 7'd0) begin bad++; $display("FAIL run_abort_clear: got loaded=%b wc=%0d want 0 0", bus0.program_loaded, bus0.word_count); end
    endtask

    task automatic test_rst_midload();
        send_word(1'b0, 32'h1122_3344);
        total++; if (bus0.word_count !== 7'd1) begin bad++; $display("FAIL midload_wc: got %0d want 1", bus0.word_count); end
        bus0.byte_valid = 1'b1;
        bus0.byte_data  = 8'hAA;
        tick();
        bus0.byte_data  = 8'hBB;
        tick();
        bus0.byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus0.loading !== 1'b0 || bus0.word_count !== 7'd0 || bus0.program_loaded !== 1'b0) begin bad++; $display("FAIL midload_rst: got load=%b wc=%0d loaded=%b want 0 0 0", bus0.loading, bus0.word_count, bus0.program_loaded); end
        bus0.load_start = 1'b1;
        tick();
        bus0.load_start = 1'b0;
        send_word(1'b0, 32'hCAFE_F00D);
        send_word(1'b0, 32'hFFFF_FFFF);
        total++; if (bus0.word_count !== 7'd2 || bus0.program_loaded !== 1'b1) begin bad++; $display("FAIL reload_done: got wc=%0d loaded=%b want 2 1", bus0.word_count, bus0.program_loaded); end
        bus0.pc_addr   = 32'd0;
        bus0.run_start = 1'b1;
        tick();
        bus0.run_start = 1'b0;
        tick();
        total++; if (bus0.instr !== 32'hCAFE_F00D || bus0.instr_valid !== 1'b1) begin bad++; $display("FAIL reload_fetch: got %h/%b want cafef00d/1", bus0.instr, bus0.instr_valid); end
    endtask

    task automatic test_depth_full();
        logic [31:0] words [5];
        words[0] = 32'h0101_0101; words[1] = 32'h0202_0202; words[2] = 32'h0303_0303;
        words[3] = 32'h0404_0404; words[4] = 32'h0505_0505;
        bus1.load_start = 1'b1;
        tick();
        bus1.load_start = 1'b0;
        for (int i = 0; i < 3; i++) send_word(1'b1, words[i]);
        total++; if (bus1.word_count !== 3'd3 || bus1.loading !== 1'b1) begin bad++; $display("FAIL full_partial: got wc=%0d load=%b want 3 1", bus1.word_count, bus1.loading); end
        send_word(1'b1, words[3]);
        total++; if (bus1.word_count !== 3'd4 || bus1.loading !== 1'b0 || bus1.program_loaded !== 1'b1) begin bad++; $display("FAIL full_stop: got wc=%0d load=%b loaded=%b want 4 0 1", bus1.word_count, bus1.loading, bus1.program_loaded); end
        send_word(1'b1, words[4]);
        total++; if (bus1.word_count !== 3'd4) begin bad++; $display("FAIL full_ignore5: got wc=%0d want 4", bus1.word_count); end
        bus1.pc_addr   = 32'd12;
        bus1.run_start = 1'b1;
        tick();
        bus1.run_start = 1'b0;
        tick();
        total++; if (bus1.instr !== 32'h0404_0404 || bus1.instr_valid !== 1'b1) begin bad++; $display("FAIL full_last_word: got %h/%b want 04040404/1", bus1.instr, bus1.instr_valid); end
        bus1.pc_addr = 32'd16;
        tick();
        total++; if (bus1.addr_err !== 1'b1 || bus1.instr_valid !== 1'b0) begin bad++; $display("FAIL full_oob: got err=%b vld=%b want 1 0", bus1.addr_err, bus1.instr_valid); end
        bus1.pc_addr = 32'd0;
        tick();
        total++; if (bus1.instr !== 32'h0101_0101 || bus1.instr_valid !== 1'b1) begin bad++; $display("FAIL full_first_word: got %h/%b want 01010101/1", bus1.instr, bus1.instr_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus0.load_start = 1'b0; bus0.byte_valid = 1'b0; bus0.byte_data = 8'h0; bus0.run_start = 1'b0;
        bus0.pc_addr    = '0;   bus0.stall      = 1'b0; bus0.flush     = 1'b0;
        bus1.load_start = 1'b0; bus1.byte_valid = 1'b0; bus1.byte_data = 8'h0; bus1.run_start = 1'b0;
        bus1.pc_addr    = '0;   bus1.stall      = 1'b0; bus1.flush     = 1'b0;
        test_reset();
        test_load();
        test_fetch();
        test_addr_err();
        test_stall_flush();
        test_rst_midload();
        test_depth_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised, debug-loadable instruction memory for the pipeline's IF stage. A byte stream from the debug unit is assembled into instruction words and written at an auto-incrementing address until a halt word or a full memory ends the load. In run mode the memory returns the instruction at the fetch PC with one-cycle latency and honours stall/flush from hazard control. Every transition is on the rising edge of `clk`.

## Interface
- `DATA_W`, 32, instruction width in bits; multiple of 8.
- `DEPTH`, 64, number of instruction words; ≥ 2.
- `PC_W`, 32, width of the fetch address.
- `BYTE_ADDR`, 1, 1: PC is a byte address, word index = `pc_addr >> log2(DATA_W/8)`; 0: PC is a word index.
- `NOP_WORD`, 0, value driven on `instr` when no valid instruction.
- `HALT_WORD`, all ones, end-of-program marker.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `load_start`  in  1  enter LOAD, clear write pointer.
- `byte_valid`  in  1  `byte_data` valid this cycle (LOAD only).
- `byte_data`  in  8  program byte, MSB of word first.
- `run_start`  in  1  enter RUN (requires `program_loaded`).
- `pc_addr`  in  PC_W  fetch address.
- `stall`  in  1  hold `instr`/`instr_valid`.
- `flush`  in  1  replace next output with NOP.
- `instr`  out  DATA_W  fetched instruction.
- `instr_valid`  out  1  `instr` is a real fetch.
- `addr_err`  out  1  one-cycle pulse: out-of-range fetch.
- `loading`  out  1  state is LOAD.
- `program_loaded`  out  1  sticky: load completed.
- `word_count`  out  clog2(DEPTH+1)  words written by last load.

## Operation
- States: IDLE (reset), LOAD, RUN.
- IDLE: `load_start` → LOAD; else `run_start` & `program_loaded` → RUN; `run_start` without `program_loaded` ignored.
- LOAD entry: write pointer = 0, byte counter = 0, `word_count` = 0, `program_loaded` = 0.
- LOAD: each `byte_valid` shifts `byte_data` into the assembly register (first byte → bits DATA_W-1:DATA_W-8). On the DATA_W/8-th byte: word written at the write pointer; pointer and `word_count` increment; byte counter clears.
- Word == `HALT_WORD`: stored, then → IDLE, `program_loaded` = 1.
- Word written at index DEPTH-1 (non-halt): → IDLE, `program_loaded` = 1; no further writes.
- `load_start` in LOAD restarts the load (pointer and counters cleared).
- RUN: `load_start` → LOAD (aborts run, outputs NOP next cycle); otherwise stays RUN.
- Fetch (RUN only), priority: `flush` > `stall` > normal.
  - flush: `instr` = NOP_WORD, `instr_valid` = 0.
  - stall: hold both.
  - normal: index < `word_count` → `instr` = mem[index], `instr_valid` = 1; otherwise `instr` = NOP_WORD, `instr_valid` = 0, `addr_err` = 1.
- BYTE_ADDR=1: PC low bits ignored (no alignment error).
- Outside RUN: `instr` = NOP_WORD, `instr_valid` = 0, `addr_err` = 0.

## Timing
- Reset values: state IDLE, `instr` = NOP_WORD, `instr_valid` = 0, `addr_err` = 0, `loading` = 0, `program_loaded` = 0, `word_count` = 0, pointer/byte counter 0. Memory array not reset; contents persist across `rst`.
- `rst` mid-load: partial word discarded; completed words stay in memory but `word_count` = 0, so they are unreachable until reload.
- Fetch latency 1 cycle: `pc_addr` at edge N → `instr` after edge N.
- First valid fetch is the cycle after the RUN transition edge.
- Write happens on the edge sampling the last byte; HALT/full → IDLE on that same edge.
- `loading` is asserted the cycle after `load_start` is sampled.
- `byte_valid` outside LOAD ignored; no backpressure (one byte per cycle accepted).

## Structure
- Shared package: state enum (IDLE/LOAD/RUN), default NOP_WORD and HALT_WORD, a `BYTES = DATA_W/8` helper.
- One sub-module `instr_word_assembler`: byte shift register + byte counter, emits `word`/`word_valid`. FSM, memory array, and fetch logic stay in the top.

## Test plan
- Reset, then `run_start` → stays IDLE, `instr` = 0, `instr_valid` = 0.
- Load bytes 20 22 18 20, then FF FF FF FF → mem[0] = 0x20221820, `word_count` = 2, `program_loaded` = 1, IDLE; `run_start`, `pc_addr` = 0 → `instr` = 0x20221820, `instr_valid` = 1 one cycle later.
- RUN, `pc_addr` = 8 (word 2 ≥ `word_count` 2) → `instr` = 0, `instr_valid` = 0, `addr_err` pulses once.
- RUN, `stall` high 3 cycles while PC changes → `instr` held; `flush` & `stall` together → NOP, `instr_valid` = 0.
- DEPTH=4, stream 5 non-halt words → 4 stored, `word_count` = 4, IDLE after 16th byte, 5th word ignored.
- `rst` after 2 bytes of word 1 → IDLE, `word_count` = 0; reload from `load_start` writes mem[0] again.
